add_pipe: RTL and testbench

Parametrised, pipelined integer adder with a carry-save front end. It supports three modes: add, subtract and three-operand add. The carry chain is split into SEG-bit segments, with one segment resolved per stage. Stages are linked by registered carries, and operand/result skew registers keep each word aligned. It sits in front of the multiplier and MAC datapaths as the shared final adder. A valid/ready handshake replaces the free-running combinational 64-bit adders.

---
 rtl/add_pipe.sv | 175 +++++++++++++++++
 tb/tb_add_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : add_pipe
// Purpose  : Pipelined integer adder with a carry-save front end. Supports
//            add, subtract and three-operand add. The carry chain is cut into
//            SEG-bit segments; one segment is resolved per stage, with the
//            carry between segments held in a register. Skew registers carry
//            resolved low slices and unconsumed high slices forward, so each
//            word stays aligned. A global stall (advance) freezes every stage
//            while the output is blocked.
// Ports    : clk, rst_n                - clock, async active-low reset
//            in_valid/in_ready         - operation handshake
//            mode, op1, op2, op3, tag  - operation (00 add, 01 sub, 10 add3,
//                                        11 add)
//            out_valid/out_ready       - result handshake
//            sum, cout, ovf, out_tag   - result
// Revision : 1.0 - initial release
// ============================================================================
module add_pipe #(
   parameter int WIDTH = 64,
   parameter int SEG   = 32,
   parameter int TAGW  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic [WIDTH-1:0] op3,
   input  logic [TAGW-1:0]  tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic [TAGW-1:0]  out_tag
);

   localparam int         c_NSEG      = WIDTH / SEG;
   localparam int         c_LAST      = c_NSEG - 1;
   localparam logic [1:0] c_MODE_SUB  = 2'b01;
   localparam logic [1:0] c_MODE_ADD3 = 2'b10;

   // Global stall: everything moves together or nothing moves.
   logic             w_adv;

   // Carry-save front end (stage C inputs).
   logic [WIDTH-1:0] w_x;
   logic [WIDTH-1:0] w_y;
   logic             w_cin;
   logic             w_is3;

   // Index k holds the registers feeding segment stage k. Index 0 is loaded
   // by stage C, index k>0 by segment stage k-1.
   // r_a : resolved result slices below segment k, X slices from k upward.
   // r_b : Y word (only slices from k upward are still meaningful).
   // r_c : carry into segment k.
   logic             r_v  [c_NSEG];
   logic [WIDTH-1:0] r_a  [c_NSEG];
   logic [WIDTH-1:0] r_b  [c_NSEG];
   logic             r_c  [c_NSEG];
   logic             r_m3 [c_NSEG];
   logic [TAGW-1:0]  r_t  [c_NSEG];

   // Per-segment adder results.
   logic [SEG:0]     w_add   [c_NSEG];
   logic [WIDTH-1:0] w_anext [c_NSEG];

   // Output registers.
   logic             r_ov;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic [TAGW-1:0]  r_otag;

   logic             w_fin_cout;
   logic             w_fin_ovf;

   assign w_adv    = !r_ov || out_ready;
   assign in_ready = w_adv;

   // ------------------------------------------------------------------------
   // Stage C operand formation. add/sub pass X and Y unreduced so the final
   // carry is the true carry of X+Y+cin and the sign bits of X/Y still give
   // the overflow test. add3 is reduced to sum/carry vectors; the carry bit
   // that would land at position WIDTH is dropped by the shift.
   // ------------------------------------------------------------------------
   always_comb begin
      w_is3 = (mode == c_MODE_ADD3);
      w_cin = (mode == c_MODE_SUB);
      w_x   = op1;
      w_y   = op2;
      if (w_is3) begin
         w_x = op1 ^ op2 ^ op3;
         w_y = ((op1 & op2) | (op1 & op3) | (op2 & op3)) << 1;
      end else if (w_cin) begin
         w_y = ~op2;
      end
   end

   // ------------------------------------------------------------------------
   // Segment adders: stage k adds slice k of X and Y plus the incoming carry
   // and splices the SEG-bit result into the forwarded word.
   // ------------------------------------------------------------------------
   for (genvar k = 0; k < c_NSEG; k++) begin : g_seg
      assign w_add[k] = {1'b0, r_a[k][k*SEG +: SEG]}
                      + {1'b0, r_b[k][k*SEG +: SEG]}
                      + {{SEG{1'b0}}, r_c[k]};

      assign w_anext[k] = (r_a[k] & ~(WIDTH'({SEG{1'b1}}) << (k*SEG)))
                        | (WIDTH'(w_add[k][SEG-1:0]) << (k*SEG));
   end

   // The top slice of X/Y is consumed only in the last stage, so r_a/r_b of
   // that stage still hold the operand sign bits. For sub, Y = ~op2, which
   // turns the "signs differ" test into the same "signs equal" test as add.
   assign w_fin_cout = !r_m3[c_LAST] && w_add[c_LAST][SEG];
   assign w_fin_ovf  = !r_m3[c_LAST]
                    && (r_a[c_LAST][WIDTH-1] == r_b[c_LAST][WIDTH-1])
                    && (w_anext[c_LAST][WIDTH-1] != r_a[c_LAST][WIDTH-1]);

   // ------------------------------------------------------------------------
   // Pipeline registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < c_NSEG; k++) begin
            r_v[k]  <= 1'b0;
            r_a[k]  <= '0;
            r_b[k]  <= '0;
            r_c[k]  <= 1'b0;
            r_m3[k] <= 1'b0;
            r_t[k]  <= '0;
         end
         r_ov   <= 1'b0;
         r_sum  <= '0;
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
         r_otag <= '0;
      end else if (w_adv) begin
         // in_ready equals advance, so in_valid here means accepted.
         r_v[0]  <= in_valid;
         r_a[0]  <= w_x;
         r_b[0]  <= w_y;
         r_c[0]  <= w_cin && !w_is3;
         r_m3[0] <= w_is3;
         r_t[0]  <= tag;

         for (int k = 0; k < c_LAST; k++) begin
            r_v[k+1]  <= r_v[k];
            r_a[k+1]  <= w_anext[k];
            r_b[k+1]  <= r_b[k];
            r_c[k+1]  <= w_add[k][SEG];
            r_m3[k+1] <= r_m3[k];
            r_t[k+1]  <= r_t[k];
         end

         r_ov   <= r_v[c_LAST];
         r_sum  <= w_anext[c_LAST];
         r_cout <= w_fin_cout;
         r_ovf  <= w_fin_ovf;
         r_otag <= r_t[c_LAST];
      end
   end

   assign out_valid = r_ov;
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign out_tag   = r_otag;

endmodule
`default_nettype wire

// File: tb/tb_add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_pipe
// Purpose  : Self-checking bench for add_pipe (WIDTH=64, SEG=32, TAGW=4).
//            Table of directed vectors with hand-computed results, plus
//            sequences for backpressure and reset during operation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_pipe;

   localparam int WIDTH = 64;
   localparam int SEG   = 32;
   localparam int TAGW  = 4;
   localparam int NVEC  = 15;

   typedef struct {
      logic [1:0]  mode;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] c;
      logic [3:0]  tg;
      logic [63:0] s;
      logic        co;
      logic        ov;
   } vec_t;

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b1;
   logic             in_valid  = 1'b0;
   logic             in_ready;
   logic [1:0]       mode      = 2'b00;
   logic [WIDTH-1:0] op1       = '0;
   logic [WIDTH-1:0] op2       = '0;
   logic [WIDTH-1:0] op3       = '0;
   logic [TAGW-1:0]  tag       = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic [TAGW-1:0]  out_tag;

   int n_vec  = 0;
   int n_fail = 0;

   vec_t        vecs [NVEC];
   logic [63:0] bp_a [6];
   logic [63:0] bp_b [6];
   logic [63:0] bp_s [6];

   always #5 clk = ~clk;

   add_pipe #(.WIDTH(WIDTH), .SEG(SEG), .TAGW(TAGW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .op1       (op1),
      .op2       (op2),
      .op3       (op3),
      .tag       (tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .out_tag   (out_tag)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single operation into an idle pipe; result must show 2 edges after
   // the accepting edge (3 cycles total).
   task automatic run_one(input vec_t v, input string name);
      int lat;
      in_valid = 1'b1;
      mode     = v.mode;
      op1      = v.a;
      op2      = v.b;
      op3      = v.c;
      tag      = v.tg;
      out_ready = 1'b1;
      #1;
      check({name, " in_ready"}, 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 10) begin
         tick();
         lat++;
      end
      check({name, " latency"}, 64'(lat), 64'd2);
      check({name, " sum"},  sum,          v.s);
      check({name, " cout"}, 64'(cout),    64'(v.co));
      check({name, " ovf"},  64'(ovf),     64'(v.ov));
      check({name, " tag"},  64'(out_tag), 64'(v.tg));
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  sent, got, stall, bad;
      bit  seen, acc;
      logic [63:0] hold_s;
      logic [3:0]  hold_t;

      // mode, a, b, c, tag, sum, cout, ovf
      vecs[0]  = '{2'b00, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'd0, 4'd3,
                   64'h0000_0001_0000_0000, 1'b0, 1'b0};
      vecs[1]  = '{2'b01, 64'd5, 64'd7, 64'd0, 4'd1,
                   64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
      vecs[2]  = '{2'b01, 64'd7, 64'd5, 64'd0, 4'd2, 64'd2, 1'b1, 1'b0};
      vecs[3]  = '{2'b01, 64'h8000_0000_0000_0000, 64'd1, 64'd0, 4'd4,
                   64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
      vecs[4]  = '{2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'd5,
                   64'h8000_0000_0000_0000, 1'b0, 1'b1};
      vecs[5]  = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'd6,
                   64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0};
      vecs[6]  = '{2'b10, 64'd1, 64'd2, 64'd3, 4'd7, 64'd6, 1'b0, 1'b0};
      vecs[7]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                   64'hFFFF_FFFF_FFFF_FFFF, 4'd8, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0};
      vecs[8]  = '{2'b11, 64'd10, 64'd20, 64'd9, 4'd9, 64'd30, 1'b0, 1'b0};
      vecs[9]  = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'd10, 64'd0, 1'b1, 1'b0};
      vecs[10] = '{2'b01, 64'd0, 64'd0, 64'd0, 4'd11, 64'd0, 1'b1, 1'b0};
      vecs[11] = '{2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 4'd12,
                   64'd0, 1'b1, 1'b1};
      vecs[12] = '{2'b10, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF,
                   64'h0000_0000_FFFF_FFFF, 4'd13, 64'h0000_0002_FFFF_FFFD, 1'b0, 1'b0};
      vecs[13] = '{2'b01, 64'h0000_0001_0000_0000, 64'd1, 64'd0, 4'd14,
                   64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0};
      vecs[14] = '{2'b00, 64'd1, 64'd1, 64'd5, 4'd15, 64'd2, 1'b0, 1'b0};

      // ---------------- reset state ----------------
      #2 rst_n = 1'b0;
      #1;
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset in_ready",  64'(in_ready),  64'd1);
      check("reset sum",       sum,            64'd0);
      check("reset cout",      64'(cout),      64'd0);
      check("reset ovf",       64'(ovf),       64'd0);
      check("reset out_tag",   64'(out_tag),   64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // ---------------- directed table ----------------
      for (int i = 0; i < NVEC; i++) begin
         run_one(vecs[i], $sformatf("v%0d", i));
      end

      // ---------------- backpressure ----------------
      for (int i = 0; i < 6; i++) begin
         bp_a[i] = 64'h0000_0000_FFFF_FFF0 + 64'(i) * 64'h0000_0001_0000_0003;
         bp_b[i] = 64'h0000_0000_0000_0011 * 64'(i + 1);
         bp_s[i] = bp_a[i] + bp_b[i];
      end
      sent  = 0;
      got   = 0;
      stall = 0;
      seen  = 1'b0;
      hold_s = '0;
      hold_t = '0;
      for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
         if (out_valid && !seen) begin
            seen   = 1'b1;
            stall  = 5;
            hold_s = sum;
            hold_t = out_tag;
         end
         out_ready = (stall == 0);
         in_valid  = (sent < 6);
         if (sent < 6) begin
            mode = 2'b00;
            op1  = bp_a[sent];
            op2  = bp_b[sent];
            op3  = 64'hDEAD;
            tag  = sent[3:0];
         end
         #1;
         if (stall > 0) begin
            check("bp in_ready low", 64'(in_ready), 64'd0);
            if (stall < 5) begin
               check("bp hold sum", sum,            hold_s);
               check("bp hold tag", 64'(out_tag),   64'(hold_t));
               check("bp hold valid", 64'(out_valid), 64'd1);
            end
         end
         if (out_valid && out_ready) begin
            check("bp tag order", 64'(out_tag), 64'(got));
            check("bp sum",       sum,          bp_s[got]);
            got++;
         end
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (acc) sent++;
         if (stall > 0) stall--;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp stall seen", 64'(seen), 64'd1);
      check("bp all received", 64'(got), 64'd6);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (out_valid) bad++;
         tick();
      end
      check("bp no duplicates", 64'(bad), 64'd0);

      // ---------------- reset mid-operation ----------------
      in_valid = 1'b1;
      mode     = 2'b00;
      op1      = 64'd100;
      op2      = 64'd1;
      tag      = 4'hA;
      tick();
      op1      = 64'd200;
      tag      = 4'hB;
      tick();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("rst out_valid now", 64'(out_valid), 64'd0);
      check("rst in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (out_valid) bad++;
         tick();
      end
      check("rst no stale result", 64'(bad), 64'd0);
      run_one('{2'b00, 64'd40, 64'd2, 64'd0, 4'hC, 64'd42, 1'b0, 1'b0}, "post-reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
